// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pwm_pkg
// Description : Shared state encoding and default width for the PWM channels.
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

    localparam int PWM_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_e;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_channel_gen.sv
`default_nettype none
// ============================================================================
// Module      : pwm_channel_gen
// Description : Single-channel servo PWM generator with boundary-shadowed
//               duty/period and a drain-to-boundary disable.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_channel_gen
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] t,
    output logic             pwm,
    output logic             period_end,
    output logic             active
);

    localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

    pwm_state_e       r_state;
    pwm_state_e       w_state_nxt;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_d_s;
    logic [WIDTH-1:0] r_t_s;
    logic             r_pwm;
    logic             r_period_end;
    logic             r_active;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic [WIDTH-1:0] w_d_nxt;
    logic [WIDTH-1:0] w_t_nxt;
    logic             w_pwm_nxt;
    logic             w_pe_nxt;
    logic             w_active_nxt;

    logic [WIDTH-1:0] w_tlast;
    logic [WIDTH-1:0] w_cnt_inc;
    logic             w_at_end;
    logic             w_new_short;

    // A zero period behaves as a one-cycle period, so the last count is 0.
    assign w_tlast     = (r_t_s == '0) ? '0 : (r_t_s - c_one);
    assign w_cnt_inc   = r_cnt + c_one;
    assign w_at_end    = (r_cnt == w_tlast);
    assign w_new_short = (t <= c_one);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_d_nxt     = r_d_s;
        w_t_nxt     = r_t_s;
        w_pwm_nxt   = 1'b0;
        w_pe_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (enable) begin
                    w_state_nxt = RUN;
                    w_d_nxt     = d;
                    w_t_nxt     = t;
                    w_pwm_nxt   = (d != '0);
                    w_pe_nxt    = w_new_short;
                end
            end
            RUN, DRAIN: begin
                if (w_at_end) begin
                    w_cnt_nxt = '0;
                    if (enable) begin
                        // Enable at the boundary reloads even out of DRAIN.
                        w_state_nxt = RUN;
                        w_d_nxt     = d;
                        w_t_nxt     = t;
                        w_pwm_nxt   = (d != '0);
                        w_pe_nxt    = w_new_short;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_state_nxt = enable ? RUN : DRAIN;
                    w_cnt_nxt   = w_cnt_inc;
                    w_pwm_nxt   = (w_cnt_inc < r_d_s);
                    w_pe_nxt    = (w_cnt_inc == w_tlast);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase

        w_active_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt        <= '0;
            r_d_s        <= '0;
            r_t_s        <= '0;
            r_pwm        <= 1'b0;
            r_period_end <= 1'b0;
            r_active     <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_nxt;
            r_d_s        <= w_d_nxt;
            r_t_s        <= w_t_nxt;
            r_pwm        <= w_pwm_nxt;
            r_period_end <= w_pe_nxt;
            r_active     <= w_active_nxt;
        end
    end

    assign pwm        = r_pwm;
    assign period_end = r_period_end;
    assign active     = r_active;

endmodule : pwm_channel_gen
`default_nettype wire

// File: tb/tb_pwm_channel_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_channel_gen
// Description : Directed self-checking bench for pwm_channel_gen.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_channel_gen;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [31:0] d;
    logic [31:0] t;
    logic        pwm;
    logic        period_end;
    logic        active;

    int checks;
    int errors;

    pwm_channel_gen #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .d          (d),
        .t          (t),
        .pwm        (pwm),
        .period_end (period_end),
        .active     (active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are sampled 1 time unit after the edge; inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        tick();
        reset  = 1'b0;
    endtask

    task automatic start(input logic [31:0] dv, input logic [31:0] tv);
        apply_reset();
        d      = dv;
        t      = tv;
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        enable = 1'b0;
        d      = 32'd3;
        t      = 32'd10;
        tick();
        checks++;
        if ({pwm, period_end, active} !== 3'b000) begin
            errors++;
            $display("FAIL reset: {pwm,pe,active}=%b expected 000", {pwm, period_end, active});
        end
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ({pwm, period_end, active} !== 3'b000) begin
                errors++;
                $display("FAIL idle k=%0d: {pwm,pe,active}=%b expected 000", k, {pwm, period_end, active});
            end
        end
    endtask

    task automatic test_basic();
        logic [2:0] exp;
        start(32'd3, 32'd10);
        for (int k = 0; k < 20; k++) begin
            tick();
            exp = {(k % 10) < 3, (k % 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL basic k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
        end
    endtask

    task automatic test_duty_change();
        logic [2:0] exp;
        start(32'd3, 32'd10);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k < 10) exp = {k < 3, k == 9, 1'b1};
            else        exp = {(k - 10) < 5, (k - 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL duty_change k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
            if (k == 4) d = 32'd5;
        end
    endtask

    task automatic test_disable();
        logic [2:0] exp;
        start(32'd3, 32'd10);
        for (int k = 0; k < 14; k++) begin
            tick();
            if (k < 10) exp = {k < 3, k == 9, 1'b1};
            else        exp = 3'b000;
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL disable k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
            if (k == 2) enable = 1'b0;
        end
    endtask

    task automatic test_reenable();
        logic [2:0] exp;
        start(32'd3, 32'd10);
        for (int k = 0; k < 20; k++) begin
            tick();
            exp = {(k % 10) < 3, (k % 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL reenable k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
            if (k == 4) enable = 1'b0;
            if (k == 7) enable = 1'b1;
        end
    endtask

    // Re-enable lands on the final drain cycle; new duty is picked up there.
    task automatic test_back_to_back();
        logic [2:0] exp;
        start(32'd3, 32'd10);
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k < 10) exp = {k < 3, k == 9, 1'b1};
            else        exp = {(k - 10) < 6, (k - 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL back_to_back k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
            if (k == 2) enable = 1'b0;
            if (k == 9) begin
                enable = 1'b1;
                d      = 32'd6;
            end
        end
    endtask

    task automatic test_boundaries();
        logic [2:0] exp;
        start(32'd0, 32'd10);
        for (int k = 0; k < 12; k++) begin
            tick();
            exp = {1'b0, (k % 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL duty_zero k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
        end
        start(32'd12, 32'd10);
        for (int k = 0; k < 12; k++) begin
            tick();
            exp = {1'b1, (k % 10) == 9, 1'b1};
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL duty_full k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
        end
        start(32'd5, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            exp = (k < 3) ? 3'b111 : 3'b011;
            checks++;
            if ({pwm, period_end, active} !== exp) begin
                errors++;
                $display("FAIL period_zero k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, exp);
            end
            if (k == 2) d = 32'd0;
        end
        start(32'd1, 32'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if ({pwm, period_end, active} !== 3'b111) begin
                errors++;
                $display("FAIL period_one k=%0d: {pwm,pe,active}=%b expected 111", k, {pwm, period_end, active});
            end
        end
    endtask

    task automatic test_reset_mid();
        start(32'd3, 32'd10);
        for (int k = 0; k < 6; k++) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({pwm, period_end, active} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid: {pwm,pe,active}=%b expected 000", {pwm, period_end, active});
        end
        enable = 1'b0;
        reset  = 1'b0;
        tick();
        checks++;
        if ({pwm, period_end, active} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid_idle: {pwm,pe,active}=%b expected 000", {pwm, period_end, active});
        end
        // After the reset the counter must restart from 0.
        enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({pwm, period_end, active} !== {k < 3, k == 9, 1'b1}) begin
                errors++;
                $display("FAIL reset_mid_restart k=%0d: {pwm,pe,active}=%b expected %b", k, {pwm, period_end, active}, {k < 3, k == 9, 1'b1});
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        enable = 1'b0;
        d      = '0;
        t      = '0;
        test_reset();
        test_basic();
        test_duty_change();
        test_disable();
        test_reenable();
        test_back_to_back();
        test_boundaries();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_pwm_channel_gen
`default_nettype wire
